vga_layer_compositor: RTL and testbench
=======================================

# vga_layer_compositor

Pipelined, parametrised pixel colour compositor for the VGA output path. Merges NUM_LAYERS overlay layers (text, board marks, cursor) with per-layer colours and fixed lowest-index priority. Draws a two-region background, split at a configurable row. Adds frame-synchronous blinking for selected layers. Sits between the layer generators and the VGA pins, and delays hsync/vsync so they stay aligned with the colour output.

## Interface
Parameters:
- NUM_LAYERS, 18, number of overlay layers; index 0 has the highest priority.
- COLOR_W, 3, bits per pixel colour.
- SPLIT_Y, 400, rows with pixel_y > SPLIT_Y use bg_bottom; all other rows use bg_top.
- BLINK_FRAMES, 30, frames per blink half-period (≥1).

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  asynchronous, active-high.
- pixel_tick  in  1  pixel enable; all state advances only when it is high.
- video_on  in  1  visible-area flag.
- pixel_x, pixel_y  in  10 each  current pixel coordinates.
- hsync_in, vsync_in  in  1 each  raw syncs, active-low.
- layer_on  in  NUM_LAYERS  per-layer pixel-hit flags.
- layer_rgb  in  NUM_LAYERS*COLOR_W  per-layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- blink_mask  in  NUM_LAYERS  layers subject to blinking.
- bg_top, bg_bottom  in  COLOR_W each  background colours.
- rgb  out  COLOR_W  registered output colour.
- hsync_out, vsync_out  out  1 each  syncs delayed to align with rgb.
- blink_phase  out  1  current blink phase; 1 = blinking layers hidden.

## Operation
- Effective hits: eff_on = layer_on & ~(blink_mask & {NUM_LAYERS{blink_phase}}).
- Stage 1 (registered on pixel_tick):
  - hit1 = |eff_on.
  - col1 = layer_rgb of the lowest set index in eff_on; 0 when there is no hit.
  - below1 = (pixel_y > SPLIT_Y), unsigned compare. Row SPLIT_Y itself is top.
  - von1 = video_on; hsync and vsync are also captured.
- Stage 2 (registered on pixel_tick):
  - rgb = 0 when !von1.
  - Otherwise rgb = col1 when hit1.
  - Otherwise rgb = bg_bottom when below1, else bg_top.
  - Syncs are delayed a second time.
- Blink timer:
  - Frame event = pixel_tick && pixel_x==0 && pixel_y==0.
  - Counter width is $clog2(BLINK_FRAMES), minimum 1 bit.
  - On a frame event: if the counter equals BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles; otherwise it increments.
  - With BLINK_FRAMES=1, blink_phase toggles every frame.
- Boundary behaviour:
  - Simultaneous hits: the lowest index wins.
  - A blinking layer that is hidden exposes the next lower-priority hit or the background, never black.
  - A frame event updates blink_phase after the edge. The pixel (0,0) uses the old phase.

## Timing
- Latency is exactly 2 pixel_tick cycles from inputs to rgb/hsync_out/vsync_out. Syncs and colour are always aligned.
- When pixel_tick is low, every register holds its value.
- Reset values:
  - rgb = 0.
  - hsync_out = vsync_out = 1 (inactive).
  - blink_phase = 0.
  - Blink counter = 0.
  - All stage-1 registers cleared; hit1 = 0, von1 = 0, stage-1 syncs = 1.
- Reset asserted mid-frame forces these values immediately. Valid output resumes 2 ticks after release.
- There is no combinational path from any input to any output.

## Configuration
- VGA_COMP_BLINK_EN defined: blink timer present and behaviour is as above.
- VGA_COMP_BLINK_EN not defined: no counter is built, blink_phase is tied to 0, and blink_mask is ignored. Latency is unchanged.

## Structure
- Shared package vga_comp_pkg holds:
  - Default COLOR_W, SPLIT_Y and BLINK_FRAMES.
  - Colour constants COLOR_BLACK = 3'b000 and COLOR_BLUE = 3'b001.
  - Helper function returning the blink-counter width.
- One sub-module, vga_priority_sel: combinational lowest-index encoder plus colour mux, taking eff_on and layer_rgb and returning hit and colour.

## Test plan
- Defaults, video_on=1, no layers, pixel_y=400 then 401, bg_top=0, bg_bottom=1 -> two ticks later rgb=0, then rgb=1.
- layer_on[3] and layer_on[7] set, rgb3=3'b100, rgb7=3'b010 -> rgb=3'b100 after 2 ticks; then clear bit 3 -> 3'b010.
- video_on=0 with layer_on all ones -> rgb=0. hsync_in pulse low for 96 ticks -> hsync_out low for the same 96 ticks, shifted by 2.
- BLINK_FRAMES=2, blink_mask[0]=1, layer_on[0]=1, rgb0=3'b111:
  - blink_phase toggles every 2 frame events.
  - Hidden phase shows background; visible phase shows 3'b111.
  - Repeat without VGA_COMP_BLINK_EN -> always 3'b111.
- Reset asserted mid-line with rgb=3'b100 -> rgb=0, syncs=1, blink_phase=0 immediately. After release, first valid rgb appears on the 2nd tick.

Source files
------------

// File: rtl/vga_comp_pkg.sv
// Shared constants and helpers for the VGA layer compositor.
// Blink logic is built only when VGA_COMP_BLINK_EN is defined.
package vga_comp_pkg;

  localparam int unsigned DEFAULT_NUM_LAYERS   = 18;
  localparam int unsigned DEFAULT_COLOR_W      = 3;
  localparam int unsigned DEFAULT_SPLIT_Y      = 400;
  localparam int unsigned DEFAULT_BLINK_FRAMES = 30;

  localparam int unsigned COORD_W = 10;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;

  // Width of the frame counter; never below one bit so BLINK_FRAMES=1 still elaborates.
  function automatic int unsigned blink_cnt_w(input int unsigned frames);
    int unsigned w;
    w = (frames > 1) ? $clog2(frames) : 1;
    return w;
  endfunction

endpackage

// File: rtl/vga_layer_compositor_if.sv
// Pixel-side bus of the compositor: layer inputs, raw syncs in, composed colour and syncs out.
interface vga_layer_compositor_if
  import vga_comp_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter int unsigned COLOR_W    = DEFAULT_COLOR_W
);

  logic                          pixel_tick;
  logic                          video_on;
  logic [COORD_W-1:0]            pixel_x;
  logic [COORD_W-1:0]            pixel_y;
  logic                          hsync_in;
  logic                          vsync_in;
  logic [NUM_LAYERS-1:0]         layer_on;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         blink_mask;
  logic [COLOR_W-1:0]            bg_top;
  logic [COLOR_W-1:0]            bg_bottom;
  logic [COLOR_W-1:0]            rgb;
  logic                          hsync_out;
  logic                          vsync_out;
  logic                          blink_phase;

  modport master (
    output pixel_tick, video_on, pixel_x, pixel_y, hsync_in, vsync_in,
    output layer_on, layer_rgb, blink_mask, bg_top, bg_bottom,
    input  rgb, hsync_out, vsync_out, blink_phase
  );

  modport slave (
    input  pixel_tick, video_on, pixel_x, pixel_y, hsync_in, vsync_in,
    input  layer_on, layer_rgb, blink_mask, bg_top, bg_bottom,
    output rgb, hsync_out, vsync_out, blink_phase
  );

endinterface

// File: rtl/vga_priority_sel.sv
// Lowest-index-wins layer selector: reports whether any layer hits and returns its colour.
module vga_priority_sel #(
  parameter int unsigned NUM_LAYERS = 18,
  parameter int unsigned COLOR_W    = 3
) (
  input  logic [NUM_LAYERS-1:0]         eff_on_i,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb_i,
  output logic                          hit_o,
  output logic [COLOR_W-1:0]            col_o
);

  // Scan from the lowest priority upward so the last assignment is the winning layer.
  always_comb begin
    hit_o = 1'b0;
    col_o = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_on_i[i]) begin
        hit_o = 1'b1;
        col_o = layer_rgb_i[i*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage pixel compositor: layer priority, split background, optional frame blink
// (VGA_COMP_BLINK_EN), with syncs delayed to stay aligned with the colour output.
module vga_layer_compositor
  import vga_comp_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = DEFAULT_NUM_LAYERS,
  parameter int unsigned COLOR_W      = DEFAULT_COLOR_W,
  parameter int unsigned SPLIT_Y      = DEFAULT_SPLIT_Y,
  parameter int unsigned BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
  input logic                    clk,
  input logic                    reset,
  vga_layer_compositor_if.slave  bus
);

  localparam logic [COORD_W-1:0] SplitYCoord = COORD_W'(SPLIT_Y);

  logic                  blink_phase;
  logic [NUM_LAYERS-1:0] eff_on;
  logic                  hit_c;
  logic [COLOR_W-1:0]    col_c;

  // Stage 1 state
  logic               hit1_q, hit1_d;
  logic [COLOR_W-1:0] col1_q, col1_d;
  logic               below1_q, below1_d;
  logic [COLOR_W-1:0] bg_top1_q, bg_top1_d;
  logic [COLOR_W-1:0] bg_bot1_q, bg_bot1_d;
  logic               von1_q, von1_d;
  logic               hs1_q, hs1_d;
  logic               vs1_q, vs1_d;

  // Stage 2 state
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               hs2_q, hs2_d;
  logic               vs2_q, vs2_d;

`ifdef VGA_COMP_BLINK_EN
  localparam int unsigned       CntW   = blink_cnt_w(BLINK_FRAMES);
  localparam logic [CntW-1:0]   CntMax = CntW'(BLINK_FRAMES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            frame_evt;

  always_comb begin
    frame_evt = bus.pixel_tick && (bus.pixel_x == '0) && (bus.pixel_y == '0);
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    if (frame_evt) begin
      if (cnt_q == CntMax) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;
`else
  logic unused_blink_inputs;

  assign unused_blink_inputs = ^{bus.blink_mask, bus.pixel_x};
  assign blink_phase         = 1'b0;
`endif

  // Hidden blinking layers drop out of the hit vector, exposing whatever lies beneath.
  assign eff_on = bus.layer_on & ~(bus.blink_mask & {NUM_LAYERS{blink_phase}});

  vga_priority_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W)
  ) u_priority_sel (
    .eff_on_i    (eff_on),
    .layer_rgb_i (bus.layer_rgb),
    .hit_o       (hit_c),
    .col_o       (col_c)
  );

  always_comb begin
    hit1_d    = hit_c;
    col1_d    = col_c;
    below1_d  = (bus.pixel_y > SplitYCoord);
    bg_top1_d = bus.bg_top;
    bg_bot1_d = bus.bg_bottom;
    von1_d    = bus.video_on;
    hs1_d     = bus.hsync_in;
    vs1_d     = bus.vsync_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1_q    <= 1'b0;
      col1_q    <= '0;
      below1_q  <= 1'b0;
      bg_top1_q <= '0;
      bg_bot1_q <= '0;
      von1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
    end else if (bus.pixel_tick) begin
      hit1_q    <= hit1_d;
      col1_q    <= col1_d;
      below1_q  <= below1_d;
      bg_top1_q <= bg_top1_d;
      bg_bot1_q <= bg_bot1_d;
      von1_q    <= von1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
    end
  end

  always_comb begin
    rgb_d = bg_top1_q;
    if (!von1_q) begin
      rgb_d = COLOR_W'(COLOR_BLACK);
    end else if (hit1_q) begin
      rgb_d = col1_q;
    end else if (below1_q) begin
      rgb_d = bg_bot1_q;
    end
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else if (bus.pixel_tick) begin
      rgb_q <= rgb_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
    end
  end

  assign bus.rgb         = rgb_q;
  assign bus.hsync_out   = hs2_q;
  assign bus.vsync_out   = vs2_q;
  assign bus.blink_phase = blink_phase;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor: vector table, hand sequences, random vs model.
module tb_vga_layer_compositor;

  localparam int unsigned NL = 18;
  localparam int unsigned CW = 3;
  localparam int unsigned BF = 2;

  logic clk = 1'b0;
  logic reset;

  vga_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

  vga_layer_compositor #(
    .NUM_LAYERS   (NL),
    .COLOR_W      (CW),
    .SPLIT_Y      (400),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: output after a tick is the composition of the inputs seen one tick earlier.
  logic [2:0] m_rgb, p_rgb;
  logic       m_hs, m_vs, p_hs, p_vs;
  int         nframes;

  typedef struct {
    logic          von;
    logic [9:0]    y;
    logic [NL-1:0] on;
    logic [2:0]    top;
    logic [2:0]    bot;
    logic [2:0]    exp;
  } vec_t;

  vec_t vecs[12];
  logic [NL*CW-1:0] base_rgb;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_phase();
`ifdef VGA_COMP_BLINK_EN
    return ((nframes / BF) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] compose(input bit ph);
    if (!bus.video_on) return 3'b000;
    for (int i = 0; i < NL; i++) begin
      if (bus.layer_on[i] && !(ph && bus.blink_mask[i])) return bus.layer_rgb[i*CW +: CW];
    end
    return (bus.pixel_y > 10'd400) ? bus.bg_bottom : bus.bg_top;
  endfunction

  task automatic model_reset();
    m_rgb = 3'b000; m_hs = 1'b1; m_vs = 1'b1;
    p_rgb = 3'b000; p_hs = 1'b1; p_vs = 1'b1;
    nframes = 0;
  endtask

  task automatic model_step();
    m_rgb = p_rgb; m_hs = p_hs; m_vs = p_vs;
    p_rgb = compose(model_phase());
    p_hs  = bus.hsync_in;
    p_vs  = bus.vsync_in;
    if (bus.pixel_x == 10'd0 && bus.pixel_y == 10'd0) nframes++;
  endtask

  // One clock; inputs are changed by the caller only after this returns (edge + 1).
  task automatic do_tick(input bit chk);
    if (bus.pixel_tick) model_step();
    @(posedge clk);
    #1;
    if (chk) begin
      check("model_rgb", int'(bus.rgb), int'(m_rgb));
      check("model_hsync", int'(bus.hsync_out), int'(m_hs));
      check("model_vsync", int'(bus.vsync_out), int'(m_vs));
      check("model_phase", int'(bus.blink_phase), int'(model_phase()));
    end
  endtask

  function automatic vec_t mk(input logic von, input logic [9:0] y, input logic [NL-1:0] on,
                              input logic [2:0] top, input logic [2:0] bot, input logic [2:0] exp);
    vec_t v;
    v.von = von; v.y = y; v.on = on; v.top = top; v.bot = bot; v.exp = exp;
    return v;
  endfunction

  initial begin
    int lows;
    int first_low;
    bit exp_ph;
    logic [63:0] lr;

    // Layer 3 = 100, layer 7 = 010, the rest (i % 7) + 1.
    for (int i = 0; i < NL; i++) begin
      base_rgb[i*CW +: CW] = (i == 3) ? 3'd4 : (i == 7) ? 3'd2 : 3'((i % 7) + 1);
    end
    vecs[0]  = mk(1'b1, 10'd400,  18'h00000, 3'd0, 3'd1, 3'd0);
    vecs[1]  = mk(1'b1, 10'd401,  18'h00000, 3'd0, 3'd1, 3'd1);
    vecs[2]  = mk(1'b1, 10'd401,  18'h00088, 3'd0, 3'd1, 3'd4);
    vecs[3]  = mk(1'b1, 10'd401,  18'h00080, 3'd0, 3'd1, 3'd2);
    vecs[4]  = mk(1'b0, 10'd401,  18'h3FFFF, 3'd0, 3'd1, 3'd0);
    vecs[5]  = mk(1'b1, 10'd0,    18'h00000, 3'd5, 3'd6, 3'd5);
    vecs[6]  = mk(1'b1, 10'd1023, 18'h00000, 3'd5, 3'd6, 3'd6);
    vecs[7]  = mk(1'b1, 10'd10,   18'h20000, 3'd5, 3'd6, 3'd4);
    vecs[8]  = mk(1'b1, 10'd10,   18'h20010, 3'd5, 3'd6, 3'd5);
    vecs[9]  = mk(1'b1, 10'd10,   18'h3FFFF, 3'd5, 3'd6, 3'd1);
    vecs[10] = mk(1'b1, 10'd500,  18'h0000C, 3'd5, 3'd6, 3'd3);
    vecs[11] = mk(1'b1, 10'd400,  18'h00000, 3'd5, 3'd6, 3'd5);

    reset          = 1'b1;
    bus.pixel_tick = 1'b0;
    bus.video_on   = 1'b0;
    bus.pixel_x    = 10'd5;
    bus.pixel_y    = 10'd5;
    bus.hsync_in   = 1'b1;
    bus.vsync_in   = 1'b1;
    bus.layer_on   = '0;
    bus.layer_rgb  = base_rgb;
    bus.blink_mask = '0;
    bus.bg_top     = 3'd0;
    bus.bg_bottom  = 3'd1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", int'(bus.rgb), 0);
    check("reset_hsync", int'(bus.hsync_out), 1);
    check("reset_vsync", int'(bus.vsync_out), 1);
    check("reset_phase", int'(bus.blink_phase), 0);
    reset = 1'b0;
    bus.pixel_tick = 1'b1;

    // Vector table: hold each pattern for two ticks, then compare with the tabulated colour.
    for (int i = 0; i < 12; i++) begin
      bus.video_on  = vecs[i].von;
      bus.pixel_y   = vecs[i].y;
      bus.layer_on  = vecs[i].on;
      bus.bg_top    = vecs[i].top;
      bus.bg_bottom = vecs[i].bot;
      do_tick(1'b1);
      do_tick(1'b1);
      check($sformatf("vec%0d_rgb", i), int'(bus.rgb), int'(vecs[i].exp));
    end

    // hsync low for 96 ticks must reappear 2 ticks later for exactly 96 ticks.
    bus.video_on = 1'b1;
    bus.layer_on = '0;
    lows = 0;
    first_low = -1;
    bus.hsync_in = 1'b0;
    for (int t = 1; t <= 104; t++) begin
      if (t == 97) bus.hsync_in = 1'b1;
      do_tick(1'b1);
      if (bus.hsync_out == 1'b0) begin
        lows++;
        if (first_low < 0) first_low = t;
      end
    end
    check("hsync_low_len", lows, 96);
    check("hsync_first_low", first_low, 2);

    // Blink: layer 0 white and masked; hidden phase shows bg_top (y=5).
    bus.layer_rgb[2:0] = 3'b111;
    bus.layer_on       = 18'h00001;
    bus.blink_mask     = 18'h00001;
    bus.bg_top         = 3'd2;
    bus.bg_bottom      = 3'd6;
    for (int k = 1; k <= 6; k++) begin
      bus.pixel_x = 10'd0;
      bus.pixel_y = 10'd0;
      do_tick(1'b1);
      bus.pixel_x = 10'd5;
      bus.pixel_y = 10'd5;
      repeat (3) do_tick(1'b1);
`ifdef VGA_COMP_BLINK_EN
      exp_ph = ((k / BF) % 2) == 1;
`else
      exp_ph = 1'b0;
`endif
      check($sformatf("blink%0d_phase", k), int'(bus.blink_phase), int'(exp_ph));
      check($sformatf("blink%0d_rgb", k), int'(bus.rgb), exp_ph ? 2 : 7);
    end

    // Mid-line reset with rgb showing 100.
    bus.layer_rgb  = base_rgb;
    bus.blink_mask = '0;
    bus.layer_on   = 18'h00008;
    bus.hsync_in   = 1'b0;
    do_tick(1'b1);
    do_tick(1'b1);
    check("pre_reset_rgb", int'(bus.rgb), 4);
    reset = 1'b1;
    #1;
    check("midreset_rgb", int'(bus.rgb), 0);
    check("midreset_hsync", int'(bus.hsync_out), 1);
    check("midreset_vsync", int'(bus.vsync_out), 1);
    check("midreset_phase", int'(bus.blink_phase), 0);
    #2;
    reset = 1'b0;
    model_reset();
    do_tick(1'b1);
    check("post_reset_tick1_rgb", int'(bus.rgb), 0);
    do_tick(1'b1);
    check("post_reset_tick2_rgb", int'(bus.rgb), 4);
    check("post_reset_tick2_hsync", int'(bus.hsync_out), 0);

    // Randomised traffic with gated pixel_tick, frame events and blinking.
    for (int t = 0; t < 600; t++) begin
      bus.pixel_tick = ($urandom_range(0, 3) != 0);
      bus.video_on   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd0;
      end else begin
        bus.pixel_x = 10'($urandom_range(0, 1023));
        bus.pixel_y = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(395, 405))
                                                  : 10'($urandom_range(0, 1023));
      end
      bus.hsync_in   = 1'($urandom());
      bus.vsync_in   = 1'($urandom());
      bus.layer_on   = NL'($urandom() & $urandom() & $urandom());
      bus.blink_mask = NL'($urandom());
      lr             = {$urandom(), $urandom()};
      bus.layer_rgb  = lr[NL*CW-1:0];
      bus.bg_top     = 3'($urandom());
      bus.bg_bottom  = 3'($urandom());
      do_tick(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
